// File: rtl/mau_pkg.sv
// -----------------------------------------------------------------------------
// mau_pkg
// Shared definitions for the memory access unit: access-size codes, the
// transaction state encoding and the lane-select width.
// Optional feature macro used by the unit: MAU_RANGE_CHECK_EN.
// -----------------------------------------------------------------------------
package mau_pkg;

    // Access size codes carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Byte-lane select width inside a 32-bit word
    localparam int LANE_W = 2;

    // Transaction states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } mau_state_e;

endpackage

// File: rtl/mau_lane_align.sv
// -----------------------------------------------------------------------------
// mau_lane_align
// Purely combinational lane steering for the memory access unit.
//   i_word   : 32-bit memory word (read data or captured word)
//   i_wdata  : right-justified store data (only the low half is ever merged)
//   i_lane   : byte address within the word (little-endian lanes)
//   i_size   : access size code
//   i_signed : sign-extend sub-word loads
//   o_load   : selected lane, zero/sign extended to 32 bits
//   o_merge  : i_word with the addressed lane replaced by store data
// -----------------------------------------------------------------------------
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [31:0]       i_word,
    input  logic [15:0]       i_wdata,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    output logic [31:0]       o_load,
    output logic [31:0]       o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword out of the word
    always_comb begin
        w_byte = 8'h00;
        case (i_lane)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_lane[1]) begin
            w_half = i_word[31:16];
        end else begin
            w_half = i_word[15:0];
        end
    end

    // Extend the selected lane into a full load result
    always_comb begin
        o_load = 32'h0000_0000;
        case (i_size)
            SZ_BYTE: o_load = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load = {{16{i_signed & w_half[15]}}, w_half};
            SZ_WORD: o_load = i_word;
            default: o_load = 32'h0000_0000;
        endcase
    end

    // Replace only the addressed lane for sub-word stores
    always_comb begin
        o_merge = i_word;
        case (i_size)
            SZ_BYTE: begin
                case (i_lane)
                    2'd0:    o_merge[7:0]   = i_wdata[7:0];
                    2'd1:    o_merge[15:8]  = i_wdata[7:0];
                    2'd2:    o_merge[23:16] = i_wdata[7:0];
                    2'd3:    o_merge[31:24] = i_wdata[7:0];
                    default: o_merge        = i_word;
                endcase
            end
            SZ_HALF: begin
                if (i_lane[1]) begin
                    o_merge[31:16] = i_wdata;
                end else begin
                    o_merge[15:0]  = i_wdata;
                end
            end
            default: o_merge = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Initiator for a word-only data memory. Takes byte/half/word loads and stores
// one at a time, performs sub-word stores as read-modify-write, and returns
// aligned, extended load data with a one-cycle response pulse.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   req_valid/req_ready      : request handshake (ready only in IDLE)
//   req_we/size/signed/addr/wdata : request fields, latched on accept
//   rsp_valid/rsp_rdata/rsp_err   : completion pulse and held result
//   address/Write_data/MemRead/MemWrite/Read_data : memory side
// Optional feature: define MAU_RANGE_CHECK_EN to flag addr[31:2] >= MEM_WORDS
// as an error; otherwise upper address bits pass straight through.
// -----------------------------------------------------------------------------
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int MEM_WORDS = 32
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] address,
    output logic [31:0] Write_data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] Read_data
);

`ifdef MAU_RANGE_CHECK_EN
    localparam logic RANGE_CHECK_ON = 1'b1;
`else
    localparam logic RANGE_CHECK_ON = 1'b0;
`endif
    localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

    mau_state_e  r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_over_range;
    logic        w_req_err;
    logic        w_word_store;
    logic [31:0] w_align_word;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign w_accept     = req_valid & req_ready;
    assign w_over_range = (req_addr[31:2] >= MEM_WORDS_W);
    assign w_req_err    = (req_size == SZ_RSVD)
                        | ((req_size == SZ_HALF) & req_addr[0])
                        | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                        | (RANGE_CHECK_ON & w_over_range);
    assign w_word_store = req_we & (req_size == SZ_WORD);

    // Loads extract straight from Read_data during READ; the RMW merge
    // works on the word captured at the end of READ.
    assign w_align_word = (r_state == ST_READ) ? Read_data : r_word;

    mau_lane_align u_lane_align (
        .i_word   (w_align_word),
        .i_wdata  (r_wdata[15:0]),
        .i_lane   (r_addr[LANE_W-1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    // Transaction FSM, request latches and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= 32'h0000_0000;
            r_wdata  <= 32'h0000_0000;
            r_word   <= 32'h0000_0000;
            r_rdata  <= 32'h0000_0000;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we     <= req_we;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        if (w_req_err) begin
                            r_state <= ST_RESP;
                            r_rdata <= 32'h0000_0000;
                            r_err   <= 1'b1;
                        end else if (w_word_store) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    r_word <= Read_data;
                    if (r_we) begin
                        r_state <= ST_WRITE;
                    end else begin
                        r_state <= ST_RESP;
                        r_rdata <= w_load;
                        r_err   <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_RESP;
                    r_rdata <= 32'h0000_0000;
                    r_err   <= 1'b0;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready is held low while reset is asserted, not just while the state is non-IDLE
    assign req_ready  = rst_n & (r_state == ST_IDLE);
    // Strobes decode directly from the async-reset state, so they drop with rst_n
    assign MemRead    = (r_state == ST_READ);
    assign MemWrite   = (r_state == ST_WRITE);
    assign address    = (MemRead | MemWrite) ? {r_addr[31:2], 2'b00} : 32'h0000_0000;
    assign Write_data = MemWrite ? ((r_size == SZ_WORD) ? r_wdata : w_merge)
                                 : 32'h0000_0000;
    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_rdata  = r_rdata;
    assign rsp_err    = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit with a word-addressed memory behind it.
// A transaction-level model predicts the per-cycle outputs of each request;
// a negedge compare process checks them, and literal checks pin key values.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
    import mau_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, MemRead, MemWrite;
    logic [31:0] rsp_rdata, address, Write_data, Read_data;

    mem_access_unit #(.MEM_WORDS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .address(address), .Write_data(Write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(Read_data)
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT
    logic [31:0] dmem [0:63] = '{default: 32'h0};
    assign Read_data = dmem[address[7:2]];
    always @(posedge clk) begin
        if (MemWrite) dmem[address[7:2]] <= Write_data;
    end

    // Expected observable outputs for one clock cycle
    typedef struct packed {
        logic        ready;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [0:63] = '{default: 32'h0};
    logic [31:0] hold_rdata = 32'h0;
    logic        hold_err = 1'b0;
    logic        en_cmp = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic ready, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic rv, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.ready = ready; e.rd = rd; e.wr = wr; e.addr = addr; e.wd = wd;
        e.rv = rv; e.rdata = rdata; e.err = err;
        return e;
    endfunction

    // Load result from a memory word by plain arithmetic
    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [1:0] size, input logic sgn);
        longint v;
        int     sh;
        v = longint'(word);
        if (size == 2'd0) begin
            sh = 8 * int'(addr % 4);
            v  = (v >> sh) % 256;
            if (sgn && v >= 128) v = v - 256;
        end else if (size == 2'd1) begin
            sh = 16 * int'((addr / 2) % 2);
            v  = (v >> sh) % 65536;
            if (sgn && v >= 32768) v = v - 65536;
        end
        return v[31:0];
    endfunction

    // Memory word after a sub-word store
    function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] wdata,
                                            input logic [31:0] addr, input logic [1:0] size);
        logic [31:0] mask, val;
        int          sh;
        if (size == 2'd0) begin
            sh   = 8 * int'(addr % 4);
            mask = 32'h0000_00FF << sh;
            val  = (wdata & 32'h0000_00FF) << sh;
        end else begin
            sh   = 16 * int'((addr / 2) % 2);
            mask = 32'h0000_FFFF << sh;
            val  = (wdata & 32'h0000_FFFF) << sh;
        end
        return (old & ~mask) | val;
    endfunction

    // Transaction model: queue the cycles following an accepted request
    task automatic model_req(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata, output int n);
        logic        err;
        logic [31:0] wa, old, nw, ld;
        int          idx;
        err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
`ifdef MAU_RANGE_CHECK_EN
        if (addr / 4 >= 32) err = 1'b1;
`endif
        wa  = addr - addr % 4;
        idx = int'((addr / 4) % 64);
        old = ref_mem[idx];
        if (err) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1));
            hold_rdata = 32'h0; hold_err = 1'b1; n = 1;
        end else if (!we) begin
            ld = m_load(old, addr, size, sgn);
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, wa, 32'h0, 1'b0, hold_rdata, hold_err));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, ld, 1'b0));
            hold_rdata = ld; hold_err = 1'b0; n = 2;
        end else if (size == 2'd2) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, wa, wdata, 1'b0, hold_rdata, hold_err));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0));
            ref_mem[idx] = wdata;
            hold_rdata = 32'h0; hold_err = 1'b0; n = 2;
        end else begin
            nw = m_merge(old, wdata, addr, size);
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, wa, 32'h0, 1'b0, hold_rdata, hold_err));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, wa, nw, 1'b0, hold_rdata, hold_err));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0));
            ref_mem[idx] = nw;
            hold_rdata = 32'h0; hold_err = 1'b0; n = 3;
        end
    endtask

    // Cycle-by-cycle compare against the model (idle expectation when queue empty)
    always @(negedge clk) begin
        exp_t e;
        if (en_cmp) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, hold_rdata, hold_err);
            chk("req_ready",  32'(req_ready), 32'(e.ready));
            chk("MemRead",    32'(MemRead),   32'(e.rd));
            chk("MemWrite",   32'(MemWrite),  32'(e.wr));
            chk("address",    address,        e.addr);
            chk("Write_data", Write_data,     e.wd);
            chk("rsp_valid",  32'(rsp_valid), 32'(e.rv));
            chk("rsp_rdata",  rsp_rdata,      e.rdata);
            chk("rsp_err",    32'(rsp_err),   32'(e.err));
        end
    end

    // Issue one request starting at a negedge with the DUT idle; returns at
    // the negedge of the idle cycle following the response.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        model_req(we, size, sgn, addr, wdata, n);
        repeat (n + 1) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  32'(req_ready), 32'h0);
        chk("rst_MemRead",    32'(MemRead),   32'h0);
        chk("rst_MemWrite",   32'(MemWrite),  32'h0);
        chk("rst_address",    address,        32'h0);
        chk("rst_Write_data", Write_data,     32'h0);
        chk("rst_rsp_valid",  32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata",  rsp_rdata,      32'h0);
        chk("rst_rsp_err",    32'(rsp_err),   32'h0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'h1);
        en_cmp = 1'b1;
        @(negedge clk);

        // Reset in the READ phase of a halfword store
        do_req(1'b1, SZ_WORD, 1'b0, 32'h14, 32'h1234_5678);
        req_we = 1'b1; req_size = SZ_HALF; req_signed = 1'b0;
        req_addr = 32'h14; req_wdata = 32'h0000_BEEF; req_valid = 1'b1;
        @(posedge clk);
        #1;
        en_cmp = 1'b0;
        @(negedge clk);
        chk("abort_read_active", 32'(MemRead), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_MemRead_drop", 32'(MemRead),   32'h0);
        chk("abort_MemWrite",     32'(MemWrite),  32'h0);
        chk("abort_rsp_valid",    32'(rsp_valid), 32'h0);
        chk("abort_ready_low",    32'(req_ready), 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_rsp",   32'(rsp_valid), 32'h0);
            chk("abort_no_write", 32'(MemWrite),  32'h0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("abort_word5_kept", dmem[5], 32'h1234_5678);
        exp_q.delete();
        hold_rdata = 32'h0; hold_err = 1'b0;
        en_cmp = 1'b1;
        @(negedge clk);

        // Word store then load
        do_req(1'b1, SZ_WORD, 1'b0, 32'h14, 32'hDEAD_BEEF);
        chk("sw_err", 32'(rsp_err), 32'h0);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0);
        chk("lw_data", rsp_rdata, 32'hDEAD_BEEF);

        // Sub-word loads with extension
        do_req(1'b1, SZ_WORD, 1'b0, 32'h14, 32'h8899_AABB);
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h17, 32'h0);
        chk("lb_17", rsp_rdata, 32'hFFFF_FF88);
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h16, 32'h0);
        chk("lbu_16", rsp_rdata, 32'h0000_0099);
        do_req(1'b0, SZ_HALF, 1'b1, 32'h16, 32'h0);
        chk("lh_16", rsp_rdata, 32'hFFFF_8899);
        do_req(1'b0, SZ_HALF, 1'b0, 32'h14, 32'h0);
        chk("lhu_14", rsp_rdata, 32'h0000_AABB);

        // Byte store read-modify-write, then a halfword store on the upper lane
        do_req(1'b1, SZ_WORD, 1'b0, 32'h14, 32'h1122_3344);
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h15, 32'hFFFF_FFA5);
        chk("sb_merge", dmem[5], 32'h1122_A544);
        do_req(1'b1, SZ_HALF, 1'b0, 32'h16, 32'h0000_BEEF);
        chk("sh_merge", dmem[5], 32'hBEEF_A544);

        // Error requests
        do_req(1'b0, SZ_WORD, 1'b0, 32'h16, 32'h0);
        chk("lw_mis_err",   32'(rsp_err), 32'h1);
        chk("lw_mis_rdata", rsp_rdata,    32'h0);
        do_req(1'b1, SZ_HALF, 1'b0, 32'h13, 32'h0000_1234);
        chk("sh_mis_err", 32'(rsp_err), 32'h1);
        chk("sh_mis_mem", dmem[4],      32'h0);
        do_req(1'b0, SZ_RSVD, 1'b0, 32'h14, 32'h0);
        chk("rsvd_err", 32'(rsp_err), 32'h1);

        // Address beyond the memory depth
        do_req(1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0);
`ifdef MAU_RANGE_CHECK_EN
        chk("range_err", 32'(rsp_err), 32'h1);
`else
        chk("range_err", 32'(rsp_err), 32'h0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
